// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: state encoding
// and the post-trigger count clamp.
package la_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_PRE_FILL  = 3'd1;
    localparam state_t ST_WAIT_TRIG = 3'd2;
    localparam state_t ST_POST      = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    // Post-trigger sample count is forced into 1..depth.
    function automatic int unsigned clamp_post(input int unsigned req, input int unsigned depth);
        if (req == 0) return 1;
        if (req > depth) return depth;
        return req;
    endfunction

endpackage

// File: rtl/capture_engine_if.sv
// Control, trigger configuration and readout bundle of the capture engine.
interface capture_engine_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PSC_W = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] i_data;
    logic             i_arm;
    logic             i_abort;
    logic             i_force_trig;
    logic [WIDTH-1:0] i_trig_mask;
    logic [WIDTH-1:0] i_trig_level;
    logic [WIDTH-1:0] i_trig_edge;
    logic [AW:0]      i_post_count;
    logic [PSC_W-1:0] i_prescaler;
    logic             i_read;
    logic [WIDTH-1:0] o_data;
    logic             o_available;
    logic             o_run;
    logic             o_triggered;
    logic [AW:0]      o_count;

    modport slave (
        input  i_data, i_arm, i_abort, i_force_trig, i_trig_mask, i_trig_level,
               i_trig_edge, i_post_count, i_prescaler, i_read,
        output o_data, o_available, o_run, o_triggered, o_count
    );

    modport master (
        output i_data, i_arm, i_abort, i_force_trig, i_trig_mask, i_trig_level,
               i_trig_edge, i_post_count, i_prescaler, i_read,
        input  o_data, o_available, o_run, o_triggered, o_count
    );

endinterface

// File: rtl/trigger_match.sv
// Combinational per-channel trigger qualifier: masked level or edge match.
module trigger_match #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_mask,
    input  logic [WIDTH-1:0] i_level,
    input  logic [WIDTH-1:0] i_edge,
    input  logic             i_prev_valid,
    output logic             o_hit
);
    logic [WIDTH-1:0] bit_ok;

    // An edge bit can only qualify once a previous sample exists.
    assign bit_ok = ~(i_data ^ i_level) &
                    (~i_edge | ({WIDTH{i_prev_valid}} & (i_prev ^ i_data)));
    assign o_hit  = &(bit_ok | ~i_mask);

endmodule

// File: rtl/capture_engine.sv
// Prescaled N-bit sampler with masked trigger, pre/post-trigger ring capture
// and oldest-first registered readout.
module capture_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PSC_W = 32
) (
    input  logic            i_clk,
    input  logic            _mrst,
    capture_engine_if.slave bus
);
    import la_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t           state_q, state_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [CW-1:0]    post_q, post_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic             force_pend_q, force_pend_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]    post_cnt_q, post_cnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             triggered_q, triggered_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic [WIDTH-1:0] ring_q [DEPTH];

    logic             run, strobe, match, hit, pop, arm_ok;
    logic             trig_take, finish, rd_load;
    logic [CW-1:0]    pre_target, total, post_clamped;
    logic [AW-1:0]    rd_addr;

    trigger_match #(.WIDTH(WIDTH)) u_trig (
        .i_data       (bus.i_data),
        .i_prev       (prev_q),
        .i_mask       (mask_q),
        .i_level      (level_q),
        .i_edge       (edge_q),
        .i_prev_valid (prev_vld_q),
        .o_hit        (match)
    );

    assign run          = state_q inside {ST_PRE_FILL, ST_WAIT_TRIG, ST_POST};
    assign strobe       = run && (psc_cnt_q == psc_q);
    assign hit          = strobe && (match || force_pend_q || bus.i_force_trig);
    assign pop          = (state_q == ST_DONE) && (count_q != '0) && bus.i_read;
    assign arm_ok       = bus.i_arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pre_target   = DEPTH_C - post_q;
    assign total        = pre_cnt_q + post_q;
    assign post_clamped = CW'(clamp_post(32'(bus.i_post_count), DEPTH));

    always_comb begin
        state_d      = state_q;
        psc_cnt_d    = psc_cnt_q;
        psc_d        = psc_q;
        post_d       = post_q;
        mask_d       = mask_q;
        level_d      = level_q;
        edge_d       = edge_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        force_pend_d = force_pend_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        triggered_d  = triggered_q;
        rd_data_d    = rd_data_q;
        trig_take    = 1'b0;
        finish       = 1'b0;
        rd_load      = 1'b0;
        rd_addr      = rd_ptr_q + AW'(1);

        if (run) psc_cnt_d = strobe ? '0 : psc_cnt_q + PSC_W'(1);
        // A forced trigger between strobes is held until the next sample.
        if (run && bus.i_force_trig) force_pend_d = 1'b1;
        if (strobe) begin
            prev_d     = bus.i_data;
            prev_vld_d = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
        end

        case (state_q)
            ST_PRE_FILL: begin
                if (hit) begin
                    trig_take = 1'b1;
                end else if (strobe) begin
                    pre_cnt_d = pre_cnt_q + CW'(1);
                    if (pre_cnt_d == pre_target) state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (hit) trig_take = 1'b1;
            end
            ST_POST: begin
                if (strobe) begin
                    post_cnt_d = post_cnt_q + CW'(1);
                    if (post_cnt_d == post_q) finish = 1'b1;
                end
            end
            ST_DONE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                    rd_load  = 1'b1;
                end
            end
            default: ;
        endcase

        if (trig_take) begin
            triggered_d  = 1'b1;
            force_pend_d = 1'b0;
            post_cnt_d   = CW'(1);
            if (post_q == CW'(1)) finish = 1'b1;
            else                  state_d = ST_POST;
        end

        // Oldest valid word sits 'total' entries behind the next write slot.
        if (finish) begin
            state_d  = ST_DONE;
            count_d  = total;
            rd_ptr_d = wr_ptr_d - AW'(total);
            rd_addr  = rd_ptr_d;
            rd_load  = 1'b1;
        end

        if (rd_load) rd_data_d = (strobe && (rd_addr == wr_ptr_q)) ? bus.i_data : ring_q[rd_addr];

        if (arm_ok || bus.i_abort) begin
            state_d      = ST_IDLE;
            psc_cnt_d    = '0;
            prev_vld_d   = 1'b0;
            force_pend_d = 1'b0;
            wr_ptr_d     = '0;
            pre_cnt_d    = '0;
            post_cnt_d   = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            triggered_d  = 1'b0;
            rd_data_d    = '0;
        end

        if (arm_ok && !bus.i_abort) begin
            state_d = (post_clamped == DEPTH_C) ? ST_WAIT_TRIG : ST_PRE_FILL;
            psc_d   = bus.i_prescaler;
            post_d  = post_clamped;
            mask_d  = bus.i_trig_mask;
            level_d = bus.i_trig_level;
            edge_d  = bus.i_trig_edge;
        end
    end

    always_ff @(posedge i_clk) begin
        if (strobe) ring_q[wr_ptr_q] <= bus.i_data;
    end

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_q      <= ST_IDLE;
            psc_cnt_q    <= '0;
            psc_q        <= '0;
            post_q       <= '0;
            mask_q       <= '0;
            level_q      <= '0;
            edge_q       <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            force_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            triggered_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            psc_cnt_q    <= psc_cnt_d;
            psc_q        <= psc_d;
            post_q       <= post_d;
            mask_q       <= mask_d;
            level_q      <= level_d;
            edge_q       <= edge_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            force_pend_q <= force_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            triggered_q  <= triggered_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.o_data      = rd_data_q;
    assign bus.o_available = (state_q == ST_DONE) && (count_q != '0);
    assign bus.o_run       = run;
    assign bus.o_triggered = triggered_q;
    assign bus.o_count     = count_q;

endmodule

// File: tb/tb_capture_engine.sv
// Bench for capture_engine (WIDTH 8, DEPTH 16): table of capture scenarios
// plus hand sequences for abort, arm-in-DONE and mid-capture reset.
module tb_capture_engine;

    logic clk  = 1'b0;
    logic mrst = 1'b1;

    always #5 clk = ~clk;

    capture_engine_if #(.WIDTH(8), .DEPTH(16), .PSC_W(32)) bus ();

    capture_engine #(.WIDTH(8), .DEPTH(16), .PSC_W(32)) dut (
        .i_clk (clk),
        ._mrst (mrst),
        .bus   (bus)
    );

    typedef struct {
        int         psc;
        logic [4:0] post;
        logic [7:0] mask;
        logic [7:0] level;
        logic [7:0] edg;
        int         rise;
        int         force_at;
        int         first;
        int         cnt;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];
    int         n_pass  = 0;
    int         n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sample k: upper bits carry k, bit0 goes high from sample 'rise' onwards.
    function automatic logic [7:0] sample(input vec_t v, input int k);
        logic [31:0] kk;
        kk = k;
        return {kk[6:0], (k >= v.rise)};
    endfunction

    task automatic pulse_abort();
        @(negedge clk);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_data"}, 32'(bus.o_data), 32'(e));
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit do_read);
        int  p;
        int  k;
        int  n;
        bit  got;
        exp_q.delete();
        p = v.psc + 1;
        pulse_abort();
        bus.i_trig_mask  = v.mask;
        bus.i_trig_level = v.level;
        bus.i_trig_edge  = v.edg;
        bus.i_post_count = v.post;
        bus.i_prescaler  = v.psc;
        bus.i_arm        = 1'b1;
        @(negedge clk);
        bus.i_arm        = 1'b0;
        // controls must be ignored once armed
        bus.i_post_count = 5'd3;
        bus.i_prescaler  = 32'd7;
        bus.i_trig_mask  = 8'hff;
        bus.i_trig_level = 8'h55;
        bus.i_trig_edge  = 8'h00;
        got = 1'b0;
        for (int j = 0; j < 400; j++) begin
            if (j > 0) @(negedge clk);
            if (bus.o_available) begin
                got = 1'b1;
                break;
            end
            k = j / p;
            bus.i_data       = sample(v, k);
            bus.i_force_trig = (v.force_at >= 0) && (j == v.force_at * p);
            if ((j % p == 0) && (k >= v.first) && (k < v.first + v.cnt))
                exp_q.push_back(sample(v, k));
        end
        bus.i_force_trig = 1'b0;
        chk({tag, "_available"}, 32'(got), 32'd1);
        chk({tag, "_triggered"}, 32'(bus.o_triggered), 32'd1);
        chk({tag, "_run"}, 32'(bus.o_run), 32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), 32'(v.cnt));
        if (do_read) begin
            n = 0;
            while (bus.o_available && n < 20) begin
                pop_check(tag);
                bus.i_read = 1'b1;
                @(negedge clk);
                n++;
            end
            bus.i_read = 1'b0;
            chk({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
            chk({tag, "_count_end"}, 32'(bus.o_count), 32'd0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_run"},       32'(bus.o_run),       32'd0);
        chk({tag, "_available"}, 32'(bus.o_available), 32'd0);
        chk({tag, "_triggered"}, 32'(bus.o_triggered), 32'd0);
        chk({tag, "_count"},     32'(bus.o_count),     32'd0);
    endtask

    initial begin
        //          psc post   mask   level  edge  rise force first cnt
        vecs[0] = '{0, 5'd8,  8'h01, 8'h01, 8'h01, 21,  -1,  13, 16};
        vecs[1] = '{3, 5'd16, 8'h00, 8'h00, 8'h00, 255, -1,  0,  16};
        vecs[2] = '{0, 5'd8,  8'h01, 8'h01, 8'h00, 3,   -1,  0,  11};
        vecs[3] = '{0, 5'd0,  8'h01, 8'h01, 8'h00, 0,   -1,  0,  1};
        vecs[4] = '{0, 5'd20, 8'h01, 8'h01, 8'h01, 4,   -1,  4,  16};
        vecs[5] = '{1, 5'd8,  8'h01, 8'h01, 8'h01, 0,   30,  22, 16};
        vecs[6] = '{0, 5'd1,  8'h01, 8'h01, 8'h00, 20,  -1,  5,  16};
        vecs[7] = '{0, 5'd8,  8'h03, 8'h02, 8'h00, 255, -1,  0,  9};

        bus.i_data = '0; bus.i_arm = 1'b0; bus.i_abort = 1'b0; bus.i_force_trig = 1'b0;
        bus.i_trig_mask = '0; bus.i_trig_level = '0; bus.i_trig_edge = '0;
        bus.i_post_count = '0; bus.i_prescaler = '0; bus.i_read = 1'b0;

        #2 mrst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_data", 32'(bus.o_data), 32'd0);
        mrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // abort while waiting for a trigger that never comes
        pulse_abort();
        bus.i_data = 8'h00; bus.i_post_count = 5'd8; bus.i_prescaler = 32'd0;
        bus.i_trig_mask = 8'h01; bus.i_trig_level = 8'h01; bus.i_trig_edge = 8'h01;
        bus.i_arm = 1'b1;
        @(negedge clk);
        bus.i_arm = 1'b0;
        repeat (15) @(negedge clk);
        chk("wait_run", 32'(bus.o_run), 32'd1);
        chk("wait_triggered", 32'(bus.o_triggered), 32'd0);
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        check_idle_outputs("abort");
        repeat (3) @(negedge clk);
        chk("abort_later_available", 32'(bus.o_available), 32'd0);

        // arm and abort together
        bus.i_arm = 1'b1; bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_arm = 1'b0; bus.i_abort = 1'b0;
        chk("arm_abort_run", 32'(bus.o_run), 32'd0);
        repeat (3) @(negedge clk);
        chk("arm_abort_run_later", 32'(bus.o_run), 32'd0);

        // arm while DONE discards unread words; arm also beats a read
        run_vec(vecs[2], "rearm", 1'b0);
        for (int i = 0; i < 2; i++) begin
            pop_check("rearm");
            bus.i_read = 1'b1;
            @(negedge clk);
        end
        bus.i_read = 1'b0;
        chk("rearm_partial_count", 32'(bus.o_count), 32'd9);
        bus.i_arm = 1'b1; bus.i_read = 1'b1;
        @(negedge clk);
        bus.i_arm = 1'b0; bus.i_read = 1'b0;
        chk("rearm_available", 32'(bus.o_available), 32'd0);
        chk("rearm_count", 32'(bus.o_count), 32'd0);
        chk("rearm_run", 32'(bus.o_run), 32'd1);
        pulse_abort();
        exp_q.delete();

        // reset asserted during POST
        bus.i_data = 8'h00; bus.i_post_count = 5'd16; bus.i_prescaler = 32'd0;
        bus.i_trig_mask = 8'h00;
        bus.i_arm = 1'b1;
        @(negedge clk);
        bus.i_arm = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_run", 32'(bus.o_run), 32'd1);
        chk("post_triggered", 32'(bus.o_triggered), 32'd1);
        #2 mrst = 1'b0;
        #1;
        check_idle_outputs("mrst");
        chk("mrst_data", 32'(bus.o_data), 32'd0);
        @(negedge clk);
        mrst = 1'b1;

        run_vec(vecs[0], "after_rst", 1'b1);
        bus.i_read = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_read = 1'b0;
        chk("empty_read_count", 32'(bus.o_count), 32'd0);
        chk("empty_read_available", 32'(bus.o_available), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
